pulse_timebase_counter: RTL and testbench
=========================================

Name: pulse_timebase_counter

Overview:
- Upstream timebase for the width2pulse window comparator.
- On an external trigger, generates a repeating count ramp 1..period on cnt_out; this drives the comparator's data_in so that each configured start/stop window emits one pulse per period.
- cnt_out rests at 0 whenever no ramp is running. 0 never satisfies the downstream "data_in > count_start" condition, so an idle timebase can never hold the pulse high.

Parameters:
WIDTH, 16, counter/period width; must match the downstream comparator data width.
REP_WIDTH, 8, width of repetition count and index.

Ports:
sys_clk  in  1  system clock (250 MHz ADC/DDS domain).
sys_rst  in  1  synchronous, active-low reset.
arm_en  in  1  level; high = accept triggers.
trig_in  in  1  trigger, synchronous to sys_clk; rising edge starts a sequence.
abort  in  1  level/pulse; forces IDLE.
period  in  WIDTH  ramp length (final count value); latched at trigger.
repeat_num  in  REP_WIDTH  number of ramps; 0 = continuous; latched at trigger.
cnt_out  out  WIDTH  ramp value to width2pulse data_in.
cnt_valid  out  1  high while a ramp is running (cnt_out != 0).
busy  out  1  high in RUN.
rep_idx  out  REP_WIDTH  0-based index of the current ramp.
period_done  out  1  one-cycle pulse on the cycle cnt_out == period.
seq_done  out  1  one-cycle pulse coincident with the final period_done.

Behaviour:
- Reset (sys_rst==0 at a sys_clk edge) forces state IDLE; all outputs 0; trigger edge register 0. This applies in any state, including mid-ramp.
- All outputs are registered.
- Trigger edge: trig_rise = trig_in & ~trig_d, with trig_d registered.
- State IDLE:
  - arm_en==1 -> ARMED next cycle.
  - Triggers are ignored in IDLE.
- State ARMED:
  - arm_en==0 -> IDLE.
  - trig_rise with latched-candidate period!=0 -> RUN.
    - Latch period into per_q and repeat_num into rep_q.
    - cnt_out=1, rep_idx=0 on the next cycle.
    - Latency: trig_in low at cycle T-1 and high at T gives cnt_out==1 at T+1.
  - trig_rise with period==0 is ignored; remain ARMED with no outputs.
- State RUN, on each cycle:
  - If cnt_out < per_q: cnt_out += 1.
  - If cnt_out == per_q: period_done=1 for this cycle. Then:
    - rep_q==0, or rep_idx+1 < rep_q: next cnt_out=1 with no gap cycle; rep_idx += 1. rep_idx wraps modulo 2^REP_WIDTH in continuous mode.
    - Otherwise: seq_done=1 this cycle. Next cnt_out=0 and rep_idx=0. Go to ARMED if arm_en==1, else IDLE.
  - period==1 yields cnt_out=1 every cycle with period_done held high.
- Triggers during RUN are ignored; they are neither queued nor restarted.
- Changes to period/repeat_num during RUN have no effect until the next trigger.
- arm_en falling during RUN has no effect; the sequence completes.
- abort==1 has priority over everything except reset.
  - Next cycle: IDLE, cnt_out=0, rep_idx=0.
  - No period_done/seq_done is emitted for the aborted ramp.
- abort and trig_rise on the same cycle: abort wins.
- busy==1 exactly while in RUN.
- cnt_valid==busy; equivalently cnt_out!=0.

Decomposition:
- Shared package ad9910_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_ARMED=2'd1, ST_RUN=2'd2.
  - Default WIDTH/REP_WIDTH constants, shared with width2pulse instances.
- One sub-module: trig_edge_detect (register plus rising-edge pulse, synchronous active-low reset). Reusable for other trigger inputs.

Test Plan:
- Reset/idle: sys_rst=0 for 5 cycles, then 1 with arm_en=0 and trig pulses -> all outputs 0 throughout; cnt_out never leaves 0.
- Single ramp: arm_en=1, period=5, repeat_num=1, trig rise at T -> cnt_out = 1,2,3,4,5 at T+1..T+5; period_done and seq_done high at T+5; cnt_out=0 and state ARMED at T+6.
- Repeats: period=3, repeat_num=3 -> cnt_out sequence 1,2,3,1,2,3,1,2,3,0 with no gaps; rep_idx 0,1,2; period_done three times; seq_done only with the third.
- Continuous plus abort: repeat_num=0, period=4, abort asserted at the 10th RUN cycle -> cnt_out=0 on the next cycle; no seq_done; triggers during RUN had no effect.
- Boundary: period=0 trig -> no RUN. period=1 repeat_num=2 -> cnt_out 1,1 with period_done on 2 cycles. Reset asserted mid-ramp -> all outputs 0 on the next cycle.
- Chained with width2pulse (count_start=0, count_stop=2), period=5 -> pulse_valid_out high exactly 2 cycles per ramp, one cycle after cnt_out 1,2; low when idle.

Source files
------------

// File: rtl/ad9910_pkg.sv
// ----------------------------------------------------------------------------
// ad9910_pkg
// Shared definitions for the AD9910 pulse timebase and the width2pulse window
// comparators it feeds.
//   state_e        : timebase FSM state encoding (IDLE / ARMED / RUN)
//   DEF_WIDTH      : default counter / comparator data width
//   DEF_REP_WIDTH  : default repetition count / index width
// ----------------------------------------------------------------------------
package ad9910_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_REP_WIDTH = 8;

endpackage

// File: rtl/trig_edge_detect.sv
// ----------------------------------------------------------------------------
// trig_edge_detect
// Registers a trigger already synchronous to clk_i and flags its rising edge.
//   clk_i   in   clock
//   rst_ni  in   synchronous active-low reset (clears the history register)
//   sig_i   in   trigger level
//   rise_o  out  high for the cycle sig_i is 1 and was 0 on the previous edge
// ----------------------------------------------------------------------------
module trig_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_d_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_d_q;

endmodule

// File: rtl/pulse_timebase_counter.sv
// ----------------------------------------------------------------------------
// pulse_timebase_counter
// Trigger-started ramp generator that feeds width2pulse data_in. Each ramp
// counts 1..period; cnt_out rests at 0 whenever no ramp is running.
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-low reset
//   arm_en       in   level, accept triggers while high
//   trig_in      in   trigger, rising edge starts a sequence
//   abort        in   forces IDLE, outranks everything but reset
//   period       in   ramp length, latched at trigger
//   repeat_num   in   ramp count (0 = continuous), latched at trigger
//   cnt_out      out  ramp value
//   cnt_valid    out  high while a ramp runs
//   busy         out  high in RUN
//   rep_idx      out  0-based index of the current ramp
//   period_done  out  pulse on the cycle cnt_out == period
//   seq_done     out  pulse with the final period_done
// ----------------------------------------------------------------------------
module pulse_timebase_counter
    import ad9910_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int REP_WIDTH = DEF_REP_WIDTH
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 arm_en,
    input  logic                 trig_in,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     period,
    input  logic [REP_WIDTH-1:0] repeat_num,
    output logic [WIDTH-1:0]     cnt_out,
    output logic                 cnt_valid,
    output logic                 busy,
    output logic [REP_WIDTH-1:0] rep_idx,
    output logic                 period_done,
    output logic                 seq_done
);

    // True when ramp number idx is the last one of a finite sequence of rep.
    // Evaluated one bit wider so rep = 2^REP_WIDTH-1 does not wrap.
    function automatic logic last_ramp(input logic [REP_WIDTH-1:0] rep,
                                       input logic [REP_WIDTH-1:0] idx);
        return (rep != '0) &&
               (({1'b0, idx} + (REP_WIDTH+1)'(1)) >= {1'b0, rep});
    endfunction

    logic trig_rise;

    trig_edge_detect u_trig_edge (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst),
        .sig_i  (trig_in),
        .rise_o (trig_rise)
    );

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     per_q, per_d;
    logic [REP_WIDTH-1:0] rep_q, rep_d;
    logic [REP_WIDTH-1:0] idx_q, idx_d;
    logic                 pd_q, pd_d;
    logic                 sd_q, sd_d;
    logic                 busy_q, busy_d;

    // period_done/seq_done are registered, so they are predicted from the
    // next count value rather than decoded from the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        pd_d    = 1'b0;
        sd_d    = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm_en) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!arm_en) begin
                        state_d = ST_IDLE;
                    end else if (trig_rise && (period != '0)) begin
                        state_d = ST_RUN;
                        per_d   = period;
                        rep_d   = repeat_num;
                        cnt_d   = WIDTH'(1);
                        idx_d   = '0;
                        pd_d    = (period == WIDTH'(1));
                        sd_d    = pd_d && last_ramp(repeat_num, '0);
                    end
                end
                ST_RUN: begin
                    if (cnt_q < per_q) begin
                        cnt_d = cnt_q + WIDTH'(1);
                        pd_d  = (cnt_d == per_q);
                        sd_d  = pd_d && last_ramp(rep_q, idx_q);
                    end else if (!last_ramp(rep_q, idx_q)) begin
                        // Restart without a gap; idx wraps in continuous mode.
                        cnt_d = WIDTH'(1);
                        idx_d = idx_q + REP_WIDTH'(1);
                        pd_d  = (per_q == WIDTH'(1));
                        sd_d  = pd_d && last_ramp(rep_q, idx_d);
                    end else begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = arm_en ? ST_ARMED : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            pd_q    <= 1'b0;
            sd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            pd_q    <= pd_d;
            sd_q    <= sd_d;
            busy_q  <= busy_d;
        end
    end

    assign cnt_out     = cnt_q;
    assign rep_idx     = idx_q;
    assign busy        = busy_q;
    assign cnt_valid   = busy_q;
    assign period_done = pd_q;
    assign seq_done    = sd_q;

endmodule

// File: tb/tb_pulse_timebase_counter.sv
// ----------------------------------------------------------------------------
// tb_pulse_timebase_counter
// Self-checking bench for pulse_timebase_counter. Expected ramps are built
// from the sequence rules: ramp r, step c gives cnt=c, rep_idx=r, with
// period_done on c==period and seq_done on the last ramp's final step.
// ----------------------------------------------------------------------------
module tb_pulse_timebase_counter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        arm_en = 1'b0;
    logic        trig_in = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] period = '0;
    logic [7:0]  repeat_num = '0;
    logic [15:0] cnt_out;
    logic        cnt_valid;
    logic        busy;
    logic [7:0]  rep_idx;
    logic        period_done;
    logic        seq_done;

    int vecs = 0;
    int miscompares = 0;

    logic [27:0] obs;
    assign obs = {cnt_out, rep_idx, busy, cnt_valid, period_done, seq_done};

    pulse_timebase_counter #(.WIDTH(16), .REP_WIDTH(8)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .arm_en      (arm_en),
        .trig_in     (trig_in),
        .abort       (abort),
        .period      (period),
        .repeat_num  (repeat_num),
        .cnt_out     (cnt_out),
        .cnt_valid   (cnt_valid),
        .busy        (busy),
        .rep_idx     (rep_idx),
        .period_done (period_done),
        .seq_done    (seq_done)
    );

    always #2 sys_clk = ~sys_clk;

    // Observable outputs implied by a ramp value: busy/valid follow cnt != 0.
    function automatic logic [27:0] exp_vec(input int c, input int i,
                                            input bit pd, input bit sd);
        logic [15:0] c16;
        logic [7:0]  i8;
        c16 = 16'(c);
        i8  = 8'(i);
        return {c16, i8, (c != 0), (c != 0), pd, sd};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic go_armed();
        abort   = 1'b0;
        trig_in = 1'b0;
        arm_en  = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            trig_in = k[0];
            arm_en  = 1'b1;
            tick();
            vecs++;
            if (obs !== exp_vec(0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %h, expected %h", k, obs, exp_vec(0, 0, 0, 0));
            end
        end
        sys_rst = 1'b1;
        arm_en  = 1'b0;
        period  = 16'd5;
        repeat_num = 8'd1;
        for (int k = 0; k < 12; k++) begin
            trig_in = (k % 3 == 0);
            tick();
            vecs++;
            if (obs !== exp_vec(0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL idle_unarmed cycle %0d: got %h, expected %h", k, obs, exp_vec(0, 0, 0, 0));
            end
        end
        trig_in = 1'b0;
    endtask

    // Runs one finite sequence p x r from ARMED and checks every cycle, then
    // probes the resting state with an immediate re-trigger.
    task automatic test_sequence(input int p, input int r, input bit noise,
                                 input string name);
        int n;
        int ec;
        bit epd, esd, final_arm;
        logic [27:0] ev;
        final_arm = 1'b1;
        go_armed();
        period     = 16'(p);
        repeat_num = 8'(r);
        trig_in    = 1'b1;
        n = p * r;
        for (int k = 0; k < n; k++) begin
            tick();
            ec  = k % p + 1;
            epd = (ec == p);
            esd = epd && (k / p == r - 1);
            ev  = exp_vec(ec, k / p, epd, esd);
            vecs++;
            if (obs !== ev) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h, expected %h", name, k, obs, ev);
            end
            if (k < n - 1) begin
                if (noise) begin
                    trig_in    = 1'($urandom_range(0, 1));
                    arm_en     = 1'($urandom_range(0, 1));
                    period     = 16'($urandom_range(0, 65535));
                    repeat_num = 8'($urandom_range(0, 255));
                end else begin
                    trig_in = 1'b0;
                end
            end else begin
                final_arm = noise ? 1'($urandom_range(0, 1)) : 1'b1;
                arm_en    = final_arm;
                trig_in   = 1'b0;
            end
        end
        tick();
        vecs++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL %s end: got %h, expected %h", name, obs, exp_vec(0, 0, 0, 0));
        end
        period     = 16'd2;
        repeat_num = 8'd1;
        trig_in    = 1'b1;
        tick();
        ev = exp_vec(final_arm ? 1 : 0, 0, 0, 0);
        vecs++;
        if (obs !== ev) begin
            miscompares++;
            $display("FAIL %s retrigger: got %h, expected %h", name, obs, ev);
        end
        abort   = 1'b1;
        trig_in = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_single();
        test_sequence(5, 1, 1'b0, "single");
    endtask

    task automatic test_repeats();
        test_sequence(3, 3, 1'b0, "repeats");
    endtask

    task automatic test_period_one();
        test_sequence(1, 2, 1'b0, "period_one");
    endtask

    task automatic test_back_to_back();
        test_sequence(2, 2, 1'b0, "back_to_back");
    endtask

    task automatic test_period_zero();
        go_armed();
        period     = 16'd0;
        repeat_num = 8'd1;
        trig_in    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++;
            if (obs !== exp_vec(0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL period_zero cycle %0d: got %h, expected %h", k, obs, exp_vec(0, 0, 0, 0));
            end
            trig_in = 1'b0;
        end
        period  = 16'd3;
        trig_in = 1'b1;
        tick();
        vecs++;
        if (obs !== exp_vec(1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL period_zero still_armed: got %h, expected %h", obs, exp_vec(1, 0, 0, 0));
        end
        abort   = 1'b1;
        trig_in = 1'b0;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_continuous_abort();
        int ec;
        logic [27:0] ev;
        go_armed();
        period     = 16'd4;
        repeat_num = 8'd0;
        trig_in    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            ec = k % 4 + 1;
            ev = exp_vec(ec, k / 4, ec == 4, 1'b0);
            vecs++;
            if (obs !== ev) begin
                miscompares++;
                $display("FAIL continuous cycle %0d: got %h, expected %h", k, obs, ev);
            end
            trig_in = 1'($urandom_range(0, 1));
        end
        abort   = 1'b1;
        trig_in = 1'b0;
        tick();
        vecs++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL abort: got %h, expected %h", obs, exp_vec(0, 0, 0, 0));
        end
        // abort lands in IDLE, which ignores this trigger even with arm_en high
        abort   = 1'b0;
        trig_in = 1'b1;
        tick();
        vecs++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL abort_to_idle: got %h, expected %h", obs, exp_vec(0, 0, 0, 0));
        end
        trig_in = 1'b0;
        tick();
        // abort and trigger together in ARMED
        abort   = 1'b1;
        trig_in = 1'b1;
        tick();
        vecs++;
        if (obs !== exp_vec(0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL abort_vs_trig: got %h, expected %h", obs, exp_vec(0, 0, 0, 0));
        end
        abort   = 1'b0;
        trig_in = 1'b0;
        tick();
    endtask

    task automatic test_idx_wrap();
        logic [27:0] ev;
        go_armed();
        period     = 16'd1;
        repeat_num = 8'd0;
        trig_in    = 1'b1;
        for (int k = 0; k < 260; k++) begin
            tick();
            ev = exp_vec(1, k % 256, 1'b1, 1'b0);
            vecs++;
            if (obs !== ev) begin
                miscompares++;
                $display("FAIL idx_wrap cycle %0d: got %h, expected %h", k, obs, ev);
            end
            trig_in = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_midramp();
        go_armed();
        period     = 16'd6;
        repeat_num = 8'd2;
        trig_in    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++;
            if (obs !== exp_vec(k + 1, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL midramp_pre cycle %0d: got %h, expected %h", k, obs, exp_vec(k + 1, 0, 0, 0));
            end
        end
        sys_rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if (obs !== exp_vec(0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL midramp_reset cycle %0d: got %h, expected %h", k, obs, exp_vec(0, 0, 0, 0));
            end
        end
        sys_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vecs++;
            if (obs !== exp_vec(0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL post_reset_idle cycle %0d: got %h, expected %h", k, obs, exp_vec(0, 0, 0, 0));
            end
        end
        trig_in = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            test_sequence(int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                          1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeats();
        test_period_one();
        test_period_zero();
        test_continuous_abort();
        test_idx_wrap();
        test_reset_midramp();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
